// File: rtl/mem_load_unit_if.sv
// Request/result bus between the load reservation stations and mem_load_unit.
// requestEnable is a valid-only push: there is no ready; back-pressure is
// signalled by the unit's full output, and a request offered while full is
// dropped. done is a one-cycle valid pulse on the common data bus with no
// ready: every listener must capture doneInst/doneRegister/doneTag in that cycle.
interface mem_load_unit_if;
  logic        requestEnable;
  logic [2:0]  requestRegister;
  logic [15:0] requestAddress;
  logic [3:0]  requestTag;
  logic        done;
  logic [15:0] doneInst;
  logic [2:0]  doneRegister;
  logic [3:0]  doneTag;

  modport master (
    output requestEnable, requestRegister, requestAddress, requestTag,
    input  done, doneInst, doneRegister, doneTag
  );

  modport slave (
    input  requestEnable, requestRegister, requestAddress, requestTag,
    output done, doneInst, doneRegister, doneTag
  );
endinterface

// File: rtl/mem_load_unit.sv
// Memory-side load responder: request FIFO, fixed-latency data memory read, CDB broadcast.
// Optional macro MEMLOAD_BYPASS_EN lets a request skip the empty FIFO when the unit is idle.
module mem_load_unit #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic                     clock,
  input  logic                     resetN,
  mem_load_unit_if.slave           bus,
  input  logic                     memWriteEnable,
  input  logic [15:0]              memWriteAddr,
  input  logic [15:0]              memWriteData,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               debugState
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BCAST  = 2'd2
  } state_t;

  state_t        state, stateN;
  logic [CW-1:0] cnt, cntN;
  logic [PW-1:0] wp, rp;

  logic [2:0]    fifoReg  [DEPTH];
  logic [AW-1:0] fifoAddr [DEPTH];
  logic [3:0]    fifoTag  [DEPTH];
  logic [15:0]   mem      [MEM_WORDS];

  logic [2:0]    workReg;
  logic [AW-1:0] workAddr;
  logic [3:0]    workTag;

  logic empty, pushFifo, pop, load, bypass, fire;
  logic unusedAddrBits;

  // Only the low AW address bits select a word; the rest alias.
  assign unusedAddrBits = ^{bus.requestAddress[15:AW], memWriteAddr[15:AW]};

  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(DEPTH));
  assign pushFifo   = bus.requestEnable && !full && !bypass;
  assign debugState = state;

  always_comb begin
    stateN = state;
    cntN   = cnt;
    pop    = 1'b0;
    load   = 1'b0;
    bypass = 1'b0;
    fire   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          cntN   = CNT_INIT;
          stateN = ACCESS;
        end
`ifdef MEMLOAD_BYPASS_EN
        else if (bus.requestEnable) begin
          bypass = 1'b1;
          load   = 1'b1;
          cntN   = CNT_INIT;
          stateN = ACCESS;
        end
`endif
      end
      ACCESS: begin
        if (cnt == '0) begin
          fire   = 1'b1;
          stateN = BCAST;
        end else begin
          cntN = cnt - 1'b1;
        end
      end
      BCAST: begin
        if (!empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          cntN   = CNT_INIT;
          stateN = ACCESS;
        end else begin
          stateN = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  // Storage without reset: memory, FIFO slots and the working register.
  always_ff @(posedge clock) begin
    if (memWriteEnable) mem[memWriteAddr[AW-1:0]] <= memWriteData;
    if (pushFifo) begin
      fifoReg[wp]  <= bus.requestRegister;
      fifoAddr[wp] <= bus.requestAddress[AW-1:0];
      fifoTag[wp]  <= bus.requestTag;
    end
    if (load) begin
      if (pop) begin
        workReg  <= fifoReg[rp];
        workAddr <= fifoAddr[rp];
        workTag  <= fifoTag[rp];
      end else begin
        workReg  <= bus.requestRegister;
        workAddr <= bus.requestAddress[AW-1:0];
        workTag  <= bus.requestTag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state            <= IDLE;
      cnt              <= '0;
      wp               <= '0;
      rp               <= '0;
      count            <= '0;
      overflow         <= 1'b0;
      bus.done         <= 1'b0;
      bus.doneInst     <= '0;
      bus.doneRegister <= '0;
      bus.doneTag      <= '0;
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      bus.done <= fire;
      if (pushFifo) wp <= wp + 1'b1;
      if (pop)      rp <= rp + 1'b1;
      count <= count + {{PW{1'b0}}, pushFifo} - {{PW{1'b0}}, pop};
      if (bus.requestEnable && full) overflow <= 1'b1;
      // Nonblocking read sees the word before any write at this same edge.
      if (fire) begin
        bus.doneInst     <= mem[workAddr];
        bus.doneRegister <= workReg;
        bus.doneTag      <= workTag;
      end
    end
  end
endmodule
